// File: rtl/mem_responder_if.sv
// Memory bus between the datapath (MAR/MDR side) and the memory responder.
// Four-phase MRD/MWR request, MACK acknowledge, MERR error pulse.
interface mem_responder_if;
  logic [15:0] MAR_in;
  logic [15:0] M_bus_wr;
  logic        MRD;
  logic        MWR;
  logic [15:0] M_bus_rd;
  logic        MACK;
  logic        MERR;
  logic        BUSY;

  modport master (
    output MAR_in, M_bus_wr, MRD, MWR,
    input  M_bus_rd, MACK, MERR, BUSY
  );

  modport slave (
    input  MAR_in, M_bus_wr, MRD, MWR,
    output M_bus_rd, MACK, MERR, BUSY
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed RAM responder with wait states and a preload port.
// Request is latched in IDLE; RAM is touched only in the one-cycle ACCESS.
module mem_responder #(
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 CLK,
  input  logic                 CLR,
  mem_responder_if.slave       m,
  input  logic                 LD_EN,
  input  logic [ADDR_BITS-1:0] LD_ADDR,
  input  logic [15:0]          LD_DATA
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT =
    (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACC,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_state_n;
  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        w_cnt_n;
  logic [ADDR_BITS-1:0] r_addr;
  logic [15:0]          r_data;
  logic                 r_is_rd;
  logic                 r_mack;
  logic                 r_merr;
  logic [15:0]          r_rdata;
  logic [15:0]          r_mem [2**ADDR_BITS];

  logic                 w_take;
  logic                 w_mack_n;
  logic                 w_merr_n;
  logic                 w_we;
  logic                 w_rd;
  logic [ADDR_BITS-1:0] w_waddr;
  logic [15:0]          w_wdata;
  logic                 w_one;
  logic                 w_both;

  assign w_one  = m.MRD ^ m.MWR;
  assign w_both = m.MRD & m.MWR;

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_take    = 1'b0;
    w_mack_n  = r_mack;
    w_merr_n  = 1'b0;
    w_we      = 1'b0;
    w_rd      = 1'b0;
    w_waddr   = r_addr;
    w_wdata   = r_data;
    unique case (r_state)
      S_IDLE: begin
        w_mack_n = 1'b0;
        // preload wins; a pending request simply retries next cycle
        if (LD_EN) begin
          w_we    = 1'b1;
          w_waddr = LD_ADDR;
          w_wdata = LD_DATA;
        end else if (w_both) begin
          w_merr_n = 1'b1;
        end else if (w_one) begin
          w_take = 1'b1;
          if (WAIT_CYCLES > 0) begin
            w_state_n = S_WAIT;
            w_cnt_n   = CNT_INIT;
          end else begin
            w_state_n = S_ACC;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) w_state_n = S_ACC;
        else             w_cnt_n   = r_cnt - 1'b1;
      end
      S_ACC: begin
        w_mack_n  = 1'b1;
        w_state_n = S_DONE;
        if (r_is_rd) w_rd = 1'b1;
        else         w_we = 1'b1;
      end
      S_DONE: begin
        if (!m.MRD && !m.MWR) begin
          w_mack_n  = 1'b0;
          w_state_n = S_IDLE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_mack  <= 1'b0;
      r_merr  <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_mack  <= w_mack_n;
      r_merr  <= w_merr_n;
      if (w_rd) r_rdata <= r_mem[r_addr];
    end
  end

  always_ff @(posedge CLK) begin
    if (w_take && !CLR) begin
      r_addr  <= m.MAR_in[ADDR_BITS-1:0];
      r_data  <= m.M_bus_wr;
      r_is_rd <= m.MRD;
    end
  end

  // contents survive reset; reset only suppresses the write
  always_ff @(posedge CLK) begin
    if (w_we && !CLR) r_mem[w_waddr] <= w_wdata;
  end

  assign m.M_bus_rd = r_rdata;
  assign m.MACK     = r_mack;
  assign m.MERR     = r_merr;
  assign m.BUSY     = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: default build plus a zero-wait build.
// Expected read data is queued at request time and popped at MACK.
module tb_mem_responder;
  localparam int W = 2;

  logic        CLK = 1'b0;
  logic        CLR = 1'b1;
  logic        LD_EN = 1'b0;
  logic [7:0]  LD_ADDR = '0;
  logic [15:0] LD_DATA = '0;
  logic        ld0_en = 1'b0;
  logic [7:0]  ld0_addr = '0;
  logic [15:0] ld0_data = '0;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] sb[$];

  mem_responder_if m();
  mem_responder_if m0();

  mem_responder #(.ADDR_BITS(8), .WAIT_CYCLES(W)) dut (
    .CLK(CLK), .CLR(CLR), .m(m),
    .LD_EN(LD_EN), .LD_ADDR(LD_ADDR), .LD_DATA(LD_DATA)
  );

  mem_responder #(.ADDR_BITS(8), .WAIT_CYCLES(0)) dut0 (
    .CLK(CLK), .CLR(CLR), .m(m0),
    .LD_EN(ld0_en), .LD_ADDR(ld0_addr), .LD_DATA(ld0_data)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic req(input bit rd, input logic [15:0] addr,
                     input logic [15:0] wd, input logic [15:0] exp,
                     input int lat, input int hold, input bit ld,
                     input logic [7:0] la, input logic [15:0] ldat);
    int k;
    logic [15:0] e;
    @(negedge CLK);
    m.MAR_in = addr;
    m.M_bus_wr = wd;
    m.MRD = rd;
    m.MWR = !rd;
    if (ld) begin
      LD_EN = 1'b1;
      LD_ADDR = la;
      LD_DATA = ldat;
    end
    if (rd) sb.push_back(exp);
    k = 0;
    do begin
      @(negedge CLK);
      k++;
      LD_EN = 1'b0;
      if (k == lat - W - 1) begin
        m.MAR_in = ~addr;
        m.M_bus_wr = ~wd;
      end
    end while (!m.MACK && k < 20);
    chk("latency", k, lat);
    if (rd) begin
      chk("sb_depth", sb.size(), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rdata", m.M_bus_rd, e);
      end
    end
    repeat (hold) begin
      @(negedge CLK);
      chk("hold_mack", m.MACK, 1);
      chk("hold_busy", m.BUSY, 1);
    end
    m.MRD = 1'b0;
    m.MWR = 1'b0;
    @(negedge CLK);
    chk("drop_mack", m.MACK, 0);
    chk("drop_busy", m.BUSY, 0);
  endtask

  task automatic req0(input bit rd, input logic [15:0] addr,
                      input logic [15:0] wd, input logic [15:0] exp);
    int k;
    logic [15:0] e;
    @(negedge CLK);
    m0.MAR_in = addr;
    m0.M_bus_wr = wd;
    m0.MRD = rd;
    m0.MWR = !rd;
    if (rd) sb.push_back(exp);
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (!m0.MACK && k < 20);
    chk("lat0", k, 2);
    if (rd && sb.size() > 0) begin
      e = sb.pop_front();
      chk("rdata0", m0.M_bus_rd, e);
    end
    m0.MRD = 1'b0;
    m0.MWR = 1'b0;
    @(negedge CLK);
    chk("drop0", m0.MACK, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    m.MAR_in = '0;
    m.M_bus_wr = '0;
    m.MRD = 1'b0;
    m.MWR = 1'b0;
    m0.MAR_in = '0;
    m0.M_bus_wr = '0;
    m0.MRD = 1'b0;
    m0.MWR = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    CLR = 1'b0;
    chk("rst_rd", m.M_bus_rd, 16'h0000);
    chk("rst_mack", m.MACK, 0);
    chk("rst_merr", m.MERR, 0);
    chk("rst_busy", m.BUSY, 0);

    req(1'b0, 16'h0012, 16'hBEEF, 16'h0, W + 2, 0, 1'b0, 8'h0, 16'h0);
    req(1'b1, 16'h0012, 16'h0, 16'hBEEF, W + 2, 5, 1'b0, 8'h0, 16'h0);

    @(negedge CLK);
    m.MAR_in = 16'h0012;
    m.M_bus_wr = 16'h0000;
    m.MRD = 1'b1;
    m.MWR = 1'b1;
    repeat (2) begin
      @(negedge CLK);
      chk("ill_merr", m.MERR, 1);
      chk("ill_mack", m.MACK, 0);
      chk("ill_busy", m.BUSY, 0);
    end
    m.MRD = 1'b0;
    m.MWR = 1'b0;
    @(negedge CLK);
    chk("ill_end", m.MERR, 0);
    req(1'b1, 16'h0012, 16'h0, 16'hBEEF, W + 2, 0, 1'b0, 8'h0, 16'h0);

    @(negedge CLK);
    LD_EN = 1'b1;
    LD_ADDR = 8'h05;
    LD_DATA = 16'h1111;
    @(negedge CLK);
    LD_EN = 1'b0;
    m.MAR_in = 16'h0005;
    m.M_bus_wr = 16'h2222;
    m.MWR = 1'b1;
    @(negedge CLK);
    chk("mw_busy", m.BUSY, 1);
    CLR = 1'b1;
    m.MWR = 1'b0;
    @(negedge CLK);
    CLR = 1'b0;
    chk("mrst_rd", m.M_bus_rd, 16'h0000);
    chk("mrst_mack", m.MACK, 0);
    chk("mrst_merr", m.MERR, 0);
    chk("mrst_busy", m.BUSY, 0);
    req(1'b1, 16'h0005, 16'h0, 16'h1111, W + 2, 0, 1'b0, 8'h0, 16'h0);

    req(1'b1, 16'hFF34, 16'h0, 16'hA5A5, W + 3, 0, 1'b1, 8'h34, 16'hA5A5);
    req(1'b0, 16'h1012, 16'hCAFE, 16'h0, W + 2, 0, 1'b0, 8'h0, 16'h0);
    req(1'b1, 16'h0012, 16'h0, 16'hCAFE, W + 2, 0, 1'b0, 8'h0, 16'h0);

    req0(1'b0, 16'h0007, 16'h1234, 16'h0);
    req0(1'b1, 16'h0107, 16'h0, 16'h1234);

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the datapath memory interface.
- Accepts read/write requests addressed by MAR, with write data taken from the MDR-to-M-bus output; returns read data on the M bus into MDR.
- Four-phase request/acknowledge handshake with a configurable number of wait states, backed by a word-addressed synchronous RAM.
- Includes a preload port for loading programs before execution.

Parameters:
ADDR_BITS, 8, number of word-address bits used; RAM depth is 2^ADDR_BITS 16-bit words.
WAIT_CYCLES, 2, wait-state cycles inserted before each access (0 allowed).

Ports:
CLK  input  1  system clock; all state changes on rising edge
CLR  input  1  synchronous active-high reset
MAR_in  input  16  address from MAR_out
M_bus_wr  input  16  write data from M_bus_out (MDR side)
MRD  input  1  read request, level, held until MACK
MWR  input  1  write request, level, held until MACK
M_bus_rd  output  16  read data toward M_bus_in
MACK  output  1  acknowledge
MERR  output  1  one-cycle pulse: illegal request (MRD and MWR both high)
BUSY  output  1  high whenever state is not IDLE
LD_EN  input  1  preload write strobe
LD_ADDR  input  ADDR_BITS  preload address
LD_DATA  input  16  preload data

Behaviour:
- Reset (CLR=1 at an edge): state=IDLE, wait counter=0, MACK=0, MERR=0, BUSY=0, M_bus_rd=16'h0000.
  - RAM contents are not cleared.
  - Reset in any state aborts the transaction; a write that has not reached ACCESS is never committed.
- Address mapping: word address = MAR_in[ADDR_BITS-1:0]; upper bits are ignored, so addresses alias (wrap modulo 2^ADDR_BITS).
- States:
  - IDLE:
    - LD_EN=1: write LD_DATA to RAM[LD_ADDR]. Any request is not accepted this cycle and is retried next cycle (preload has priority).
    - Otherwise, exactly one of MRD/MWR high: latch address, direction and (for write) M_bus_wr. Go to WAIT if WAIT_CYCLES>0, with counter = WAIT_CYCLES-1; else go to ACCESS.
    - MRD=MWR=1: stay in IDLE and pulse MERR for one cycle. MERR keeps pulsing every cycle both remain high.
  - WAIT: counter decrements each edge. When counter==0, go to ACCESS. LD_EN is ignored.
  - ACCESS (exactly one cycle):
    - Read: M_bus_rd <= RAM[latched addr].
    - Write: RAM[latched addr] <= latched data.
    - MACK <= 1; go to DONE.
  - DONE:
    - MACK held at 1 while MRD or MWR is high.
    - When MRD=MWR=0 is sampled: MACK <= 0, go to IDLE.
- Latency: request accepted at edge E0 → MACK rises at edge E0+WAIT_CYCLES+1. With default 2, MACK is seen 3 cycles after acceptance.
- Minimum request-to-request spacing: the next request is accepted no earlier than one edge after returning to IDLE.
- A request held high after MACK never retriggers; a new transaction needs the request to go low, then high again.
- MAR_in and M_bus_wr changes after acceptance are ignored.
- LD_EN outside IDLE is ignored.
- M_bus_rd holds the last read value; it is updated only by a read's ACCESS and is unchanged by writes and preloads.
- BUSY=1 in WAIT, ACCESS and DONE.
- RAM is read synchronously; there is no combinational path from any input to any output.

Test Plan:
- Write then read:
  - MWR with MAR_in=16'h0012, M_bus_wr=16'hBEEF → MACK at acceptance+3; drop MWR → IDLE.
  - Then MRD at 16'h0012 → M_bus_rd=16'hBEEF at the MACK rise.
- Handshake hold: keep MRD high for 5 cycles after MACK → MACK stays 1, no second access (counter at 0, BUSY=1). Drop MRD → MACK=0 one edge later.
- Illegal request: MRD=MWR=1 for 2 cycles in IDLE → MERR pulses 2 cycles, state remains IDLE, RAM unchanged, MACK=0.
- Reset mid-write:
  - Preload RAM[5]=16'h1111.
  - MWR to address 5 with data 16'h2222; assert CLR during WAIT.
  - Then read address 5 → 16'h1111; after reset, outputs were all 0.
- Alias and preload priority:
  - LD_EN with LD_ADDR=8'h34, LD_DATA=16'hA5A5 in the same cycle as MRD to 16'hFF34 → preload happens first; read accepted next cycle.
  - M_bus_rd=16'hA5A5.
- WAIT_CYCLES=0 build: read is accepted at E0 and MACK rises at E0+1.
